// File: rtl/core_test_pkg.sv
// Shared types and default constants for the core test controller.
package core_test_pkg;

  localparam int unsigned DEF_XLEN       = 32;
  localparam int unsigned DEF_NUM_CHECKS = 8;
  localparam int unsigned DEF_CYC_W      = 16;
  localparam int unsigned DEF_RST_CYCLES = 2;
  localparam int unsigned REG_IDX_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/core_test_ctrl_cycle_counter.sv
// Clearable, enabled up-counter holding the number of RUN cycles executed.
module cycle_counter
  import core_test_pkg::*;
#(
  parameter int unsigned CYC_W = DEF_CYC_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CYC_W-1:0] o_count
);

  logic [CYC_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CYC_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/core_test_ctrl.sv
// Test sequencer: resets a core, runs it to a halt PC or cycle limit, then
// walks the register-file debug port comparing expected values.
module core_test_ctrl
  import core_test_pkg::*;
#(
  parameter int unsigned XLEN       = DEF_XLEN,
  parameter int unsigned NUM_CHECKS = DEF_NUM_CHECKS,
  parameter int unsigned CYC_W      = DEF_CYC_W,
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [CYC_W-1:0]                   cycle_limit,
  input  logic                               halt_en,
  input  logic [XLEN-1:0]                    halt_pc,
  input  logic [NUM_CHECKS-1:0]              check_valid,
  input  logic [NUM_CHECKS*REG_IDX_W-1:0]    check_reg,
  input  logic [NUM_CHECKS*XLEN-1:0]         check_val,
  input  logic [XLEN-1:0]                    core_pc,
  input  logic [XLEN-1:0]                    rf_rdata,
  output logic                               core_rst,
  output logic                               core_en,
  output logic [REG_IDX_W-1:0]               rf_raddr,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic                               timeout,
  output logic [$clog2(NUM_CHECKS+1)-1:0]    fail_count,
  output logic [$clog2(NUM_CHECKS)-1:0]      first_fail_idx,
  output logic [CYC_W-1:0]                   cycles_run
);

  localparam int unsigned IDX_W = $clog2(NUM_CHECKS);
  localparam int unsigned FC_W  = $clog2(NUM_CHECKS + 1);
  localparam int unsigned RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);
  localparam logic [RC_W-1:0]  LAST_RST = RC_W'(RST_CYCLES - 1);

  state_e                 r_state, w_state_next;
  logic [RC_W-1:0]        r_rst_cnt, w_rst_cnt_next;
  logic [IDX_W-1:0]       r_chk_idx, w_chk_idx_next;
  logic [FC_W-1:0]        r_fail_count, w_fail_next;
  logic [IDX_W-1:0]       r_first_fail, w_first_fail_next;
  logic                   r_timeout, w_timeout_next;
  logic                   r_pass, w_pass_next;
  logic                   w_cnt_clr, w_cnt_en, w_mismatch;
  logic [CYC_W-1:0]       w_cycles, w_cycles_inc;

  logic [REG_IDX_W-1:0]   w_reg_arr [NUM_CHECKS];
  logic [XLEN-1:0]        w_val_arr [NUM_CHECKS];

  for (genvar g = 0; g < NUM_CHECKS; g++) begin : g_unpack
    assign w_reg_arr[g] = check_reg[g*REG_IDX_W +: REG_IDX_W];
    assign w_val_arr[g] = check_val[g*XLEN +: XLEN];
  end

  cycle_counter #(
    .CYC_W(CYC_W)
  ) u_cycle_counter (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_count(w_cycles)
  );

  assign w_cycles_inc = w_cycles + CYC_W'(1);

  always_comb begin
    w_state_next      = r_state;
    w_rst_cnt_next    = r_rst_cnt;
    w_chk_idx_next    = r_chk_idx;
    w_fail_next       = r_fail_count;
    w_first_fail_next = r_first_fail;
    w_timeout_next    = r_timeout;
    w_pass_next       = r_pass;
    w_cnt_clr         = 1'b0;
    w_cnt_en          = 1'b0;
    w_mismatch        = 1'b0;
    core_rst          = 1'b0;
    core_en           = 1'b0;
    rf_raddr          = '0;
    busy              = 1'b0;
    done              = 1'b0;

    case (r_state)
      ST_IDLE: core_rst = 1'b1;
      ST_DONE: done     = 1'b1;
      ST_RESET: begin
        core_rst = 1'b1;
        busy     = 1'b1;
        if (r_rst_cnt == LAST_RST) begin
          w_state_next = (cycle_limit == '0) ? ST_CHECK : ST_RUN;
        end else begin
          w_rst_cnt_next = r_rst_cnt + RC_W'(1);
        end
      end
      ST_RUN: begin
        core_en  = 1'b1;
        busy     = 1'b1;
        w_cnt_en = 1'b1;
        // Halt match is tested first so a halt on the limit cycle is not a timeout.
        if (halt_en && (core_pc == halt_pc)) begin
          w_state_next   = ST_CHECK;
          w_timeout_next = 1'b0;
        end else if (w_cycles_inc == cycle_limit) begin
          w_state_next   = ST_CHECK;
          w_timeout_next = halt_en;
        end
      end
      ST_CHECK: begin
        busy       = 1'b1;
        rf_raddr   = w_reg_arr[r_chk_idx];
        w_mismatch = check_valid[r_chk_idx] && (rf_rdata != w_val_arr[r_chk_idx]);
        if (w_mismatch) begin
          w_fail_next = r_fail_count + FC_W'(1);
          if (r_fail_count == '0) begin
            w_first_fail_next = r_chk_idx;
          end
        end
        if (r_chk_idx == LAST_IDX) begin
          w_state_next = ST_DONE;
          w_pass_next  = (w_fail_next == '0) && !r_timeout;
        end else begin
          w_chk_idx_next = r_chk_idx + IDX_W'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (((r_state == ST_IDLE) || (r_state == ST_DONE)) && start) begin
      w_state_next      = ST_RESET;
      w_rst_cnt_next    = '0;
      w_chk_idx_next    = '0;
      w_fail_next       = '0;
      w_first_fail_next = '0;
      w_timeout_next    = 1'b0;
      w_pass_next       = 1'b0;
      w_cnt_clr         = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rst_cnt    <= '0;
      r_chk_idx    <= '0;
      r_fail_count <= '0;
      r_first_fail <= '0;
      r_timeout    <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_rst_cnt    <= w_rst_cnt_next;
      r_chk_idx    <= w_chk_idx_next;
      r_fail_count <= w_fail_next;
      r_first_fail <= w_first_fail_next;
      r_timeout    <= w_timeout_next;
      r_pass       <= w_pass_next;
    end
  end

  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign fail_count     = r_fail_count;
  assign first_fail_idx = r_first_fail;
  assign cycles_run     = w_cycles;

endmodule

// File: tb/tb_core_test_ctrl.sv
// Scoreboard bench for core_test_ctrl driving a tiny behavioural core model.
module tb_core_test_ctrl;

  localparam int XLEN = 32;
  localparam int NC   = 8;
  localparam int CW   = 16;

  typedef logic [7:0][31:0] rf_t;
  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [31:0] imm;
  } instr_t;
  typedef struct packed {
    logic        pass;
    logic        to;
    logic [3:0]  fc;
    logic [2:0]  ffi;
    logic [15:0] cyc;
  } exp_t;

  localparam logic [2:0] OP_NOP = 3'd0, OP_ADDI = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3, OP_BNE = 3'd4;

  logic              clk, rst, start, halt_en;
  logic [CW-1:0]     cycle_limit;
  logic [XLEN-1:0]   halt_pc, core_pc, rf_rdata;
  logic [NC-1:0]     check_valid;
  logic [NC*5-1:0]   check_reg;
  logic [NC*XLEN-1:0] check_val;
  logic              core_rst, core_en, busy, done, pass, timeout;
  logic [4:0]        rf_raddr;
  logic [3:0]        fail_count;
  logic [2:0]        first_fail_idx;
  logic [CW-1:0]     cycles_run;

  core_test_ctrl #(.XLEN(XLEN), .NUM_CHECKS(NC), .CYC_W(CW), .RST_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cycle_limit(cycle_limit), .halt_en(halt_en),
    .halt_pc(halt_pc), .check_valid(check_valid), .check_reg(check_reg), .check_val(check_val),
    .core_pc(core_pc), .rf_rdata(rf_rdata), .core_rst(core_rst), .core_en(core_en),
    .rf_raddr(rf_raddr), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx), .cycles_run(cycles_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, n_pushed = 0, done_events = 0;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- toy core: program 0 = arithmetic, 1 = counting loop
  function automatic instr_t mk(input logic [2:0] op, input int rd, input int rs1, input int rs2, input int imm);
    mk = '{op: op, rd: 3'(rd), rs1: 3'(rs1), rs2: 3'(rs2), imm: 32'(imm)};
  endfunction

  function automatic instr_t fetch(input int sel, input logic [31:0] pc);
    instr_t i;
    i = '0;
    if (sel == 0) begin
      case (pc)
        32'h0:  i = mk(OP_ADDI, 1, 0, 0, 10);
        32'h4:  i = mk(OP_ADDI, 2, 0, 0, 5);
        32'h8:  i = mk(OP_ADD,  3, 1, 2, 0);
        32'hC:  i = mk(OP_SUB,  4, 1, 2, 0);
        default: i = '0;
      endcase
    end else begin
      case (pc)
        32'h0:  i = mk(OP_ADDI, 2, 0, 0, 5);
        32'h4:  i = mk(OP_ADDI, 1, 1, 0, 1);
        32'h8:  i = mk(OP_BNE,  0, 1, 2, -4);
        default: i = '0;
      endcase
    end
    return i;
  endfunction

  function automatic void step(input int sel, input logic [31:0] pc, input rf_t r,
                               output logic [31:0] npc, output rf_t nr);
    instr_t i;
    i   = fetch(sel, pc);
    nr  = r;
    npc = pc + 32'd4;
    case (i.op)
      OP_ADDI: nr[i.rd] = r[i.rs1] + i.imm;
      OP_ADD:  nr[i.rd] = r[i.rs1] + r[i.rs2];
      OP_SUB:  nr[i.rd] = r[i.rs1] - r[i.rs2];
      OP_BNE:  if (r[i.rs1] != r[i.rs2]) npc = pc + i.imm;
      default: ;
    endcase
    nr[0] = '0;
  endfunction

  int   prog_sel = 0;
  logic [31:0] m_pc;
  rf_t  m_regs;

  assign core_pc  = m_pc;
  assign rf_rdata = (rf_raddr < 5'd8) ? m_regs[rf_raddr[2:0]] : '0;

  always @(posedge clk) begin : core_model
    logic [31:0] npc;
    rf_t nr;
    if (core_rst === 1'b1) begin
      m_pc   <= '0;
      m_regs <= '0;
    end else if (core_en === 1'b1) begin
      step(prog_sel, m_pc, m_regs, npc, nr);
      m_pc   <= npc;
      m_regs <= nr;
    end
  end

  // ---------------- reference model: run program, then grade checks
  function automatic void run_prog(output logic [15:0] cyc, output logic to, output rf_t r);
    logic [31:0] pc, npc;
    rf_t nr;
    bit fin;
    pc = '0; r = '0; cyc = '0; to = 1'b0; fin = 1'b0;
    for (int unsigned n = 1; n <= int'(cycle_limit) && !fin; n++) begin
      if (halt_en && pc == halt_pc) begin
        cyc = 16'(n); to = 1'b0; fin = 1'b1;
      end
      step(prog_sel, pc, r, npc, nr);
      pc = npc; r = nr;
      if (!fin && n == int'(cycle_limit)) begin
        cyc = 16'(n); to = halt_en; fin = 1'b1;
      end
    end
  endfunction

  function automatic exp_t predict();
    exp_t e;
    rf_t r;
    logic [31:0] got;
    run_prog(e.cyc, e.to, r);
    e.fc = '0; e.ffi = '0;
    for (int i = 0; i < NC; i++) begin
      got = (check_reg[i*5 +: 5] < 5'd8) ? r[check_reg[i*5 +: 3]] : '0;
      if (check_valid[i] && got != check_val[i*XLEN +: XLEN]) begin
        if (e.fc == 0) e.ffi = 3'(i);
        e.fc = e.fc + 4'd1;
      end
    end
    e.pass = (e.fc == 0) && !e.to;
    return e;
  endfunction

  // ---------------- monitor
  logic prev_done = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1 && prev_done !== 1'b1) begin
      done_events++;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        e = sb_q.pop_front();
        chk("pass", pass, e.pass);
        chk("timeout", timeout, e.to);
        chk("fail_count", fail_count, e.fc);
        chk("first_fail_idx", first_fail_idx, e.ffi);
        chk("cycles_run", cycles_run, e.cyc);
        chk("done_core_rst", core_rst, 1'b0);
      end
    end
    prev_done = done;
    if (busy === 1'b0) begin
      chk("idle_rf_raddr", rf_raddr, 0);
      chk("idle_core_en", core_en, 0);
    end
  end

  // ---------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_chk();
    check_valid = '0; check_reg = '0; check_val = '0;
  endtask

  task automatic set_chk(input int ch, input int r, input logic [31:0] v);
    check_valid[ch]        = 1'b1;
    check_reg[ch*5 +: 5]   = 5'(r);
    check_val[ch*32 +: 32] = v;
  endtask

  task automatic setup_arith(input logic [31:0] hpc, input int lim);
    prog_sel = 0; halt_en = 1'b1; halt_pc = hpc; cycle_limit = 16'(lim);
    clear_chk();
    set_chk(0, 1, 10); set_chk(1, 2, 5); set_chk(2, 3, 15); set_chk(3, 4, 5);
  endtask

  task automatic launch_exp(input exp_t e);
    sb_q.push_back(e);
    n_pushed++;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 300 && done !== 1'b1; k++) tick();
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_wait: got done=%b expected 1 within 300 cycles", name, done);
    end
    tick();
  endtask

  task automatic check_reset(input string name);
    chk({name, "_core_rst"}, core_rst, 1);
    chk({name, "_core_en"}, core_en, 0);
    chk({name, "_rf_raddr"}, rf_raddr, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_pass"}, pass, 0);
    chk({name, "_timeout"}, timeout, 0);
    chk({name, "_fail_count"}, fail_count, 0);
    chk({name, "_first_fail_idx"}, first_fail_idx, 0);
    chk({name, "_cycles_run"}, cycles_run, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rc;
    logic rto;
    rf_t rr;
    rst = 1'b1; start = 1'b0; halt_en = 1'b0; halt_pc = '0; cycle_limit = '0;
    clear_chk();
    repeat (3) tick();
    check_reset("por");
    rst = 1'b0;
    tick();

    // arithmetic program halting at 0x18
    setup_arith(32'h18, 20);
    launch_exp('{pass: 1'b1, to: 1'b0, fc: 4'd0, ffi: 3'd0, cyc: 16'd7});
    wait_done("arith");
    repeat (3) tick();
    chk("held_done", done, 1);
    chk("held_pass", pass, 1);

    // counting loop, no halt detection, runs to the limit
    prog_sel = 1; halt_en = 1'b0; halt_pc = '0; cycle_limit = 16'd19;
    clear_chk(); set_chk(0, 1, 5);
    launch_exp('{pass: 1'b1, to: 1'b0, fc: 4'd0, ffi: 3'd0, cyc: 16'd19});
    wait_done("loop");

    // two mismatches, lowest on channel 2
    setup_arith(32'h18, 20);
    set_chk(2, 3, 16); set_chk(5, 1, 0);
    launch_exp('{pass: 1'b0, to: 1'b0, fc: 4'd2, ffi: 3'd2, cyc: 16'd7});
    wait_done("mismatch");

    // unreachable halt PC -> timeout
    setup_arith(32'h400, 10);
    launch_exp('{pass: 1'b0, to: 1'b1, fc: 4'd0, ffi: 3'd0, cyc: 16'd10});
    wait_done("timeout");

    // reset on the third RUN cycle, then a normal run
    setup_arith(32'h18, 20);
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    chk("run3_core_en", core_en, 1);
    chk("run3_cycles", cycles_run, 2);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset("mid_run");
    launch_exp('{pass: 1'b1, to: 1'b0, fc: 4'd0, ffi: 3'd0, cyc: 16'd7});
    wait_done("after_rst");

    // reset in the middle of CHECK
    cycle_limit = '0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    chk("midchk_busy", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset("mid_check");

    // zero limit: straight to CHECK, core never enabled, start ignored while busy
    prog_sel = 0; halt_en = 1'b1; halt_pc = 32'h18; cycle_limit = '0;
    clear_chk(); set_chk(0, 1, 0);
    launch_exp('{pass: 1'b1, to: 1'b0, fc: 4'd0, ffi: 3'd0, cyc: 16'd0});
    for (int k = 0; k < 40 && done !== 1'b1; k++) begin
      chk("lim0_core_en", core_en, 0);
      start = (k == 5);
      tick();
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL lim0_wait: got done=%b expected 1", done);
    end
    tick();
    repeat (3) tick();
    chk("lim0_stays_done", done, 1);

    // randomized runs graded by the reference model
    for (int t = 0; t < 24; t++) begin
      prog_sel    = int'($urandom % 2);
      halt_en     = 1'($urandom % 2);
      halt_pc     = ($urandom % 4 == 0) ? 32'h400 : 32'($urandom % 16) * 32'd4;
      cycle_limit = 16'($urandom % 26);
      run_prog(rc, rto, rr);
      clear_chk();
      for (int ch = 0; ch < NC; ch++) begin
        int r;
        r = int'($urandom % 8);
        check_valid[ch]        = 1'($urandom % 2);
        check_reg[ch*5 +: 5]   = 5'(r);
        check_val[ch*32 +: 32] = rr[r] ^ (($urandom % 4 == 0) ? ($urandom | 32'd1) : 32'd0);
      end
      launch_exp(predict());
      wait_done("rand");
      if ($urandom % 2 == 1) tick();
    end

    repeat (3) tick();
    chk("sb_empty", sb_q.size(), 0);
    chk("done_events", done_events, n_pushed);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
